// File: rtl/regbank_dump_ctrl_pkg.sv
// Shared definitions for the register-bank dump sequencer: FSM state
// encodings and helpers that derive byte-lane geometry from the word width.
package regbank_dump_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Number of bytes serialised per register word (word width is a multiple of 8).
  function automatic int bytes_per_word(input int word_wide);
    return word_wide / 8;
  endfunction

  // Width of the byte index; kept at least one bit so a byte-wide word still
  // has a legal index register.
  function automatic int byte_idx_bits(input int word_wide);
    int bpw;
    bpw = word_wide / 8;
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

endpackage

// File: rtl/regbank_dump_ctrl_if.sv
// Bank read port plus byte-wide transmit handshake used by the dump sequencer.
// master = the sequencer, slave = register-bank mux and UART TX side.
interface regbank_dump_ctrl_if #(
  parameter int addr_bits = 5,
  parameter int word_wide = 32
);
  logic [addr_bits-1:0] rbAddr;
  logic                 rbSel;
  logic [word_wide-1:0] rbData;
  logic [7:0]           txData;
  logic                 txValid;
  logic                 txReady;

  modport master (
    output rbAddr, rbSel, txData, txValid,
    input  rbData, txReady
  );

  modport slave (
    input  rbAddr, rbSel, txData, txValid,
    output rbData, txReady
  );
endinterface

// File: rtl/regbank_dump_ctrl_word_serializer.sv
// Holds one fetched register word and presents it LSB byte first. The byte
// index advances on every accepted transfer; last_fire marks the handshake
// that consumes the final byte so the sequencer can move on.
module regbank_dump_ctrl_word_serializer
  import regbank_dump_ctrl_pkg::*;
#(
  parameter int word_wide = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [word_wide-1:0] load_word,
  input  logic                 send,
  input  logic                 ready,
  output logic [7:0]           byte_out,
  output logic                 last_fire
);

  localparam int BYTES_PER_WORD = bytes_per_word(word_wide);
  localparam int IDX_W          = byte_idx_bits(word_wide);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [word_wide-1:0]                word_q, word_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [BYTES_PER_WORD-1:0][7:0]      lanes;
  logic                                fire;

  assign lanes     = word_q;
  assign fire      = send & ready;
  assign last_fire = fire & (idx_q == LAST_IDX);
  // Output is forced to zero outside SEND so a stale word never shows on the link.
  assign byte_out  = send ? lanes[idx_q] : 8'h00;

  // Next word/index: load on fetch, step the index on each accepted byte.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    word_d = word_q;
    idx_d  = idx_q;
    if (load) begin
      word_d = load_word;
      idx_d  = '0;
    end else if (fire) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // Word and index registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/regbank_dump_ctrl.sv
// Debug sequencer: on start, takes the bank read port, walks every address,
// latches each word and streams it byte-wise to the UART TX handshake.
// All outputs decode from registered state only.
module regbank_dump_ctrl
  import regbank_dump_ctrl_pkg::*;
#(
  parameter int addr_bits = 5,
  parameter int word_wide = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  regbank_dump_ctrl_if.master dbg_bus,
  output logic                busy,
  output logic                done
);

  state_e               state_q, state_d;
  logic [addr_bits-1:0] addr_q, addr_d;
  logic                 in_fetch;
  logic                 in_send;
  logic                 last_fire;

  assign in_fetch = (state_q == ST_FETCH);
  assign in_send  = (state_q == ST_SEND);

  regbank_dump_ctrl_word_serializer #(
    .word_wide (word_wide)
  ) u_word_serializer (
    .clock     (clock),
    .reset     (reset),
    .load      (in_fetch),
    .load_word (dbg_bus.rbData),
    .send      (in_send),
    .ready     (dbg_bus.txReady),
    .byte_out  (dbg_bus.txData),
    .last_fire (last_fire)
  );

  assign dbg_bus.rbAddr  = addr_q;
  assign dbg_bus.rbSel   = in_fetch | in_send;
  assign dbg_bus.txValid = in_send;
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);

  // Next-state and address counter: the address only advances after the last
  // byte of a word is accepted, and stops at all-ones instead of wrapping.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          addr_d  = '0;
        end
      end
      ST_FETCH: state_d = ST_SEND;
      ST_SEND: begin
        if (last_fire) begin
          if (addr_q != '1) begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // State and address registers; reset abandons any dump in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_regbank_dump_ctrl.sv
// Bench for regbank_dump_ctrl: a cycle table for the start of a dump, plus a
// byte scoreboard filled from a bank model whenever a dump is requested.
module tb_regbank_dump_ctrl;

  localparam int AB     = 5;
  localparam int WW     = 32;
  localparam int NREG   = 1 << AB;
  localparam int BPW    = WW / 8;
  localparam int NBYTES = NREG * BPW;
  localparam int DUMP_CYCLES = 1 + NREG * (1 + BPW);   // start cycle to done cycle

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  regbank_dump_ctrl_if #(.addr_bits(AB), .word_wide(WW)) dbg ();

  regbank_dump_ctrl #(.addr_bits(AB), .word_wide(WW)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .dbg_bus (dbg),
    .busy    (busy),
    .done    (done)
  );

  logic [WW-1:0] bank [NREG];
  assign dbg.rbData = bank[dbg.rbAddr];

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ready driver ----------------
  bit ready_toggle = 1'b0;
  initial begin
    dbg.txReady = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      dbg.txReady = ready_toggle ? ~dbg.txReady : 1'b1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;
  int rx_cnt = 0, done_cnt = 0, done_cyc = -1, stall_cnt = 0, start_cyc = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clock) begin
    if (!reset) begin
      if (prev_valid && !prev_ready && !prev_rst) begin
        check("stall_valid_held", {31'd0, dbg.txValid}, 32'd1);
        check("stall_data_held", {24'd0, dbg.txData}, {24'd0, prev_data});
      end
      if (dbg.txValid && dbg.txReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got 0x%0h expected no transfer (cycle %0d)", dbg.txData, cyc);
        end else begin
          exp_b = exp_q.pop_front();
          check("tx_byte", {24'd0, dbg.txData}, {24'd0, exp_b});
        end
        rx_cnt++;
      end
      if (dbg.txValid && !dbg.txReady) stall_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_valid = dbg.txValid;
    prev_ready = dbg.txReady;
    prev_rst   = reset;
    prev_data  = dbg.txData;
  end

  // ---------------- helpers ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic push_expected();
    for (int r = 0; r < NREG; r++)
      for (int b = 0; b < BPW; b++)
        exp_q.push_back(bank[r][8*b +: 8]);
  endtask

  task automatic clear_stats();
    rx_cnt    = 0;
    done_cnt  = 0;
    stall_cnt = 0;
    done_cyc  = -1;
  endtask

  // Start held for one cycle; afterwards the caller is in the following cycle.
  task automatic pulse_start();
    next_cycle();
    start     = 1'b1;
    start_cyc = cyc;
    push_expected();
    clear_stats();
    next_cycle();
    start = 1'b0;
  endtask

  // Returns in the cycle after the done pulse, i.e. the first IDLE cycle.
  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      next_cycle();
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, budget);
    end else begin
      check({name, "_idle_after_done"}, {31'd0, busy}, 32'd0);
      check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    end
  endtask

  task automatic check_stream(input string name);
    check({name, "_bytes"}, rx_cnt, NBYTES);
    check({name, "_queue_drained"}, exp_q.size(), 0);
    check({name, "_done_count"}, done_cnt, 1);
  endtask

  function automatic logic [31:0] all_outs();
    return {busy, done, dbg.rbSel, dbg.txValid, dbg.txData, 15'd0, dbg.rbAddr};
  endfunction

  // ---------------- cycle table ----------------
  typedef struct {
    bit         rst;
    bit         st;
    bit         exp_busy;
    bit         exp_sel;
    bit         exp_valid;
    bit         exp_done;
    logic [7:0] exp_data;
    logic [4:0] exp_addr;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < NREG; n++) bank[n] = 32'h11111111 * (n % 16) + n;

    // rst st  busy sel val done data    addr
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 8'h00, 5'd0};
    vecs[1]  = '{0, 1, 0, 0, 0, 0, 8'h00, 5'd0};  // IDLE, start sampled
    vecs[2]  = '{0, 0, 1, 1, 0, 0, 8'h00, 5'd0};  // FETCH reg 0
    vecs[3]  = '{0, 0, 1, 1, 1, 0, 8'h00, 5'd0};  // reg 0 = 0
    vecs[4]  = '{0, 0, 1, 1, 1, 0, 8'h00, 5'd0};
    vecs[5]  = '{0, 0, 1, 1, 1, 0, 8'h00, 5'd0};
    vecs[6]  = '{0, 0, 1, 1, 1, 0, 8'h00, 5'd0};
    vecs[7]  = '{0, 0, 1, 1, 0, 0, 8'h00, 5'd1};  // FETCH reg 1
    vecs[8]  = '{0, 0, 1, 1, 1, 0, 8'h12, 5'd1};  // reg 1 = 0x11111112
    vecs[9]  = '{0, 0, 1, 1, 1, 0, 8'h11, 5'd1};
    vecs[10] = '{0, 0, 1, 1, 1, 0, 8'h11, 5'd1};
    vecs[11] = '{0, 0, 1, 1, 1, 0, 8'h11, 5'd1};
    vecs[12] = '{0, 0, 1, 1, 0, 0, 8'h00, 5'd2};  // FETCH reg 2

    // ---- reset, then idle ----
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      check("idle_outputs", all_outs(), 32'd0);
    end

    // ---- table-driven start of a full dump, txReady high ----
    for (int i = 0; i < 13; i++) begin
      @(posedge clock);
      #1;
      reset = vecs[i].rst;
      start = vecs[i].st;
      if (vecs[i].st) begin
        start_cyc = cyc;
        push_expected();
        clear_stats();
      end
      @(negedge clock);
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
      check($sformatf("vec%0d_rbsel", i), {31'd0, dbg.rbSel}, {31'd0, vecs[i].exp_sel});
      check($sformatf("vec%0d_txvalid", i), {31'd0, dbg.txValid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vecs[i].exp_done});
      check($sformatf("vec%0d_txdata", i), {24'd0, dbg.txData}, {24'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_rbaddr", i), {27'd0, dbg.rbAddr}, {27'd0, vecs[i].exp_addr});
    end
    start = 1'b0;
    wait_done("full", 400);
    check("full_done_cycle", done_cyc - start_cyc, DUMP_CYCLES);
    check_stream("full");

    // ---- txReady toggling every cycle ----
    ready_toggle = 1'b1;
    pulse_start();
    wait_done("toggle", 800);
    ready_toggle = 1'b0;
    check("toggle_stalls_seen", {31'd0, stall_cnt > 0}, 32'd1);
    check("toggle_done_cycle", done_cyc - start_cyc, DUMP_CYCLES + stall_cnt);
    check_stream("toggle");

    // ---- start re-asserted while busy ----
    pulse_start();
    for (int n = 0; n < 400; n++) begin
      next_cycle();
      if (done_cnt > 0) begin
        start = 1'b0;
        break;
      end
      start = ((cyc - start_cyc) % 37 == 0);
    end
    start = 1'b0;
    for (int i = 0; i < 10; i++) next_cycle();
    check_stream("restart_ignored");

    // ---- reset during byte 2 of reg 7 ----
    pulse_start();
    while (cyc < start_cyc + 1 + 7 * (1 + BPW) + 3) next_cycle();
    check("abort_point_addr", {27'd0, dbg.rbAddr}, 32'd7);
    check("abort_point_byte", {24'd0, dbg.txData}, {24'd0, bank[7][23:16]});
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    check("reset_outputs_zero", all_outs(), 32'd0);
    check("reset_bytes_before_abort", rx_cnt, 7 * BPW + 2);
    exp_q.delete();
    next_cycle();
    next_cycle();
    check("reset_no_done", done_cnt, 0);
    pulse_start();
    wait_done("after_reset", 400);
    check("after_reset_done_cycle", done_cyc - start_cyc, DUMP_CYCLES);
    check_stream("after_reset");

    // ---- bank write to the word being sent ----
    begin
      bit hit;
      logic [WW-1:0] saved;
      hit   = 1'b0;
      saved = bank[3];
      pulse_start();
      for (int n = 0; n < 100 && !hit; n++) begin
        if (dbg.txValid && dbg.rbAddr == 5'd3) begin
          bank[3] = 32'hDEADBEEF;
          hit     = 1'b1;
        end else begin
          next_cycle();
        end
      end
      check("midword_write_reached", {31'd0, hit}, 32'd1);
      wait_done("midword", 400);
      check_stream("midword");
      bank[3] = saved;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
